// File: rtl/id_pkg.sv
// Shared definitions for the identifier-detect FSM and the token capture block.
// Character classes, state encoding and record field widths live here.
package id_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LZ    = 8'h7A;
    localparam logic [7:0] ASCII_UA    = 8'h41;
    localparam logic [7:0] ASCII_UZ    = 8'h5A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int CHAR_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TOKEN = 1'b1
    } tok_state_t;

    // Fixed-width tail of a token record; the length field is sized by MAX_LEN.
    typedef struct packed {
        logic              trunc;
        logic [CHAR_W-1:0] first;
        logic [CHAR_W-1:0] last;
    } rec_tail_t;

    localparam int REC_TAIL_W = $bits(rec_tail_t);

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic is_alnum(input logic [7:0] c);
        return ((c >= ASCII_0)  && (c <= ASCII_9))  ||
               ((c >= ASCII_LA) && (c <= ASCII_LZ)) ||
               ((c >= ASCII_UA) && (c <= ASCII_UZ));
    endfunction

endpackage

// File: rtl/id_token_capture_if.sv
// Token record stream between the capture block and its consumer.
// Handshake: a record transfers at a rising edge where rec_valid & rec_ready; while
// rec_valid=1 and rec_ready=0 the producer holds every rec_* field stable.
interface id_token_capture_if #(
    parameter int LEN_W = 4
) ();

    logic             rec_valid;
    logic             rec_ready;
    logic [LEN_W-1:0] rec_len;
    logic             rec_trunc;
    logic [7:0]       rec_first;
    logic [7:0]       rec_last;

    modport master (
        output rec_valid,
        output rec_len,
        output rec_trunc,
        output rec_first,
        output rec_last,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_len,
        input  rec_trunc,
        input  rec_first,
        input  rec_last,
        output rec_ready
    );

endinterface

// File: rtl/tok_fifo.sv
// Registered first-word-fall-through FIFO for token records.
// Outputs read zero while empty so the record bus has a defined reset value.
module tok_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Callers qualify push/pop, so a push while full only arrives alongside a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/id_token_capture.sv
// Delimits alphanumeric tokens, keeps those that ended as identifiers and queues
// {len, trunc, first, last} records to a valid/ready consumer with saturating stats.
module id_token_capture
    import id_pkg::*;
#(
    parameter int MAX_LEN    = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           char,
    input  logic                 match,
    id_token_capture_if.master   rec,
    output logic [CNT_W-1:0]     id_count,
    output logic [CNT_W-1:0]     drop_count,
    output tok_state_t           dbg_state
);

    localparam int LEN_W = len_width(MAX_LEN);
    localparam int REC_W = LEN_W + REC_TAIL_W;

    logic [7:0]       d_char;
    tok_state_t       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             trunc_q, trunc_d;
    logic [7:0]       first_q, first_d;
    logic [7:0]       last_q, last_d;
    logic             hit_q, hit_d;
    logic             tok_end;
    logic             push;
    logic             drop;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] fifo_dout;
    rec_tail_t        tail;

    // match refers to the char sampled one edge earlier, so delay char to pair them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_char <= ASCII_SPACE;
        end else begin
            d_char <= char;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            trunc_q <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
            first_q <= first_d;
            last_q  <= last_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        first_d = first_q;
        last_d  = last_q;
        hit_d   = hit_q;
        tok_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_alnum(d_char)) begin
                    state_d = ST_TOKEN;
                    len_d   = LEN_W'(1);
                    trunc_d = 1'b0;
                    first_d = d_char;
                    last_d  = d_char;
                    hit_d   = match;
                end
            end
            ST_TOKEN: begin
                if (is_alnum(d_char)) begin
                    if (len_q == LEN_W'(MAX_LEN)) begin
                        trunc_d = 1'b1;
                    end else begin
                        len_d = len_q + 1'b1;
                    end
                    last_d = d_char;
                    hit_d  = match;
                end else begin
                    tok_end = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the consumer pops on the same edge.
    assign pop  = !fifo_empty && rec.rec_ready;
    assign push = tok_end && hit_q && (!fifo_full || rec.rec_ready);
    assign drop = tok_end && hit_q && fifo_full && !rec.rec_ready;

    assign tail = '{trunc: trunc_q, first: first_q, last: last_q};

    tok_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({len_q, tail}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rec.rec_valid = !fifo_empty;
    assign {rec.rec_len, rec.rec_trunc, rec.rec_first, rec.rec_last} = fifo_dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_count   <= '0;
            drop_count <= '0;
        end else begin
            if (push && (id_count != '1)) begin
                id_count <= id_count + 1'b1;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign dbg_state = state_q;

endmodule
